// File: rtl/musb_div_seq_if.sv
// Operand/result bundle between the MUSB execute stage and the divider.
// The master drives ops and operands; the slave returns results and status.
interface musb_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             op_divs;
  logic             op_divu;
  logic             abort;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output op_divs, op_divu, abort, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  op_divs, op_divu, abort, dividend, divisor,
    output quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/musb_div_seq.sv
// Multi-cycle restoring divider, one quotient bit per cycle, signed/unsigned.
// Define MUSB_DIV_ZERO_CHECK_EN to short-circuit zero divisors and flag them.
module musb_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic            clk,
  input logic            rst,
  musb_div_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] residual;
  logic [WIDTH-1:0] denom;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;
  logic             busy_q;
  logic             done_q;

  logic             start;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   partial;

  assign start = bus.op_divs | bus.op_divu;
  assign a_neg = bus.op_divs & bus.dividend[WIDTH-1];
  assign b_neg = bus.op_divs & bus.divisor[WIDTH-1];
  assign mag_a = a_neg ? -bus.dividend : bus.dividend;
  assign mag_b = b_neg ? -bus.divisor : bus.divisor;

  // Full-width shift keeps the residual exact even for divisors >= 2^(W-1).
  assign shifted = {residual, work[WIDTH-1]};
  assign partial = shifted - {1'b0, denom};

  assign bus.quotient  = q_q;
  assign bus.remainder = r_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef MUSB_DIV_ZERO_CHECK_EN
  logic zero_flag;
  logic dz_q;
  assign bus.div_zero = dz_q;
`else
  assign bus.div_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      work     <= '0;
      residual <= '0;
      denom    <= '0;
      q_q      <= '0;
      r_q      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MUSB_DIV_ZERO_CHECK_EN
      zero_flag <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MUSB_DIV_ZERO_CHECK_EN
      dz_q   <= 1'b0;
`endif
      if (bus.abort) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else if (start) begin
        state    <= RUN;
        busy_q   <= 1'b1;
        work     <= mag_a;
        denom    <= mag_b;
        residual <= '0;
        cnt      <= '0;
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
`ifdef MUSB_DIV_ZERO_CHECK_EN
        zero_flag <= (bus.divisor == '0);
        if (bus.divisor == '0) begin
          state    <= FIX;
          work     <= '1;
          residual <= bus.dividend;
          neg_q    <= 1'b0;
          neg_r    <= 1'b0;
        end
`endif
      end else begin
        unique case (state)
          RUN: begin
            if (!partial[WIDTH]) begin
              residual <= partial[WIDTH-1:0];
              work     <= {work[WIDTH-2:0], 1'b1};
            end else begin
              residual <= shifted[WIDTH-1:0];
              work     <= {work[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) state <= FIX;
          end
          FIX: begin
            q_q    <= neg_q ? -work : work;
            r_q    <= neg_r ? -residual : residual;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
`ifdef MUSB_DIV_ZERO_CHECK_EN
            dz_q   <= zero_flag;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_musb_div_seq.sv
// Self-checking bench for musb_div_seq: vector table, scoreboard,
// and hand-written abort/restart/reset sequences.
module tb_musb_div_seq;
  localparam int W = 32;
`ifdef MUSB_DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           t0;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  vec_t tbl[12];

  musb_div_seq_if #(.WIDTH(W)) ifc ();

  musb_div_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic vec_t model(input logic s, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    vec_t v;
    logic [W-1:0] ma, mb, mq, mr;
    logic nq, nr;
    v.s = s; v.a = a; v.b = b; v.dz = 1'b0;
    nq = s & (a[W-1] ^ b[W-1]);
    nr = s & a[W-1];
    ma = (s && a[W-1]) ? -a : a;
    mb = (s && b[W-1]) ? -b : b;
    if (b == '0) begin
      mq = '1;
      mr = ma;
      if (ZCHK) begin
        nq = 1'b0; nr = 1'b0; mr = a; v.dz = 1'b1;
      end
    end else begin
      mq = ma / mb;
      mr = ma % mb;
    end
    v.q = nq ? -mq : mq;
    v.r = nr ? -mr : mr;
    return v;
  endfunction

  task automatic start_op(input vec_t v, input bit replace);
    exp_t e;
    if (replace) sb.delete();
    e.q = v.q; e.r = v.r; e.dz = v.dz; e.t0 = cyc;
    e.lat = (ZCHK && v.b == '0) ? 2 : W + 2;
    sb.push_back(e);
    ifc.op_divs  = v.s;
    ifc.op_divu  = !v.s;
    ifc.dividend = v.a;
    ifc.divisor  = v.b;
    step(1);
    ifc.op_divs  = 1'b0;
    ifc.op_divu  = 1'b0;
    ifc.dividend = $urandom;
    ifc.divisor  = $urandom;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      fail("done_timeout");
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ifc.done) begin
      if (sb.size() == 0) begin
        fail("unexpected_done");
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", ifc.quotient, mon_e.q);
        chk("remainder", ifc.remainder, mon_e.r);
        chk("div_zero", W'(ifc.div_zero), W'(mon_e.dz));
        chk("latency", W'(cyc - mon_e.t0), W'(mon_e.lat));
        chk("busy_in_done", W'(ifc.busy), '0);
        last_q = mon_e.q;
        last_r = mon_e.r;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int bcnt;
    bit seen;
    vec_t v;
    tbl[0]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    tbl[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    tbl[2]  = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0};
    tbl[3]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0};
    tbl[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
    tbl[5]  = '{1'b0, 32'hFFFFFFFF, 32'h80000001, 32'd1, 32'h7FFFFFFE, 1'b0};
    tbl[6]  = '{1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0};
    tbl[7]  = '{1'b1, 32'h80000000, 32'd1, 32'h80000000, 32'd0, 1'b0};
    tbl[8]  = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
    tbl[9]  = '{1'b1, 32'h80000000, 32'h80000000, 32'd1, 32'd0, 1'b0};
    tbl[10] = '{1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, ZCHK};
    tbl[11] = '{1'b1, 32'hFFFFFFF9, 32'd0,
                ZCHK ? 32'hFFFFFFFF : 32'd1, 32'hFFFFFFF9, ZCHK};

    ifc.op_divs = 1'b0; ifc.op_divu = 1'b0; ifc.abort = 1'b0;
    ifc.dividend = '0; ifc.divisor = '0;
    step(3);
    @(negedge clk);
    chk("reset_q", ifc.quotient, '0);
    chk("reset_r", ifc.remainder, '0);
    chk("reset_flags", W'({ifc.busy, ifc.done, ifc.div_zero}), '0);
    rst = 1'b0;
    step(1);

    // busy length on the basic unsigned case
    start_op(tbl[0], 1'b0);
    bcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ifc.done) break;
      if (ifc.busy) bcnt++;
    end
    chk("busy_cycles", W'(bcnt), W'(W + 1));
    wait_idle(W + 10);
    step(1);

    for (int i = 0; i < 12; i++) begin
      start_op(tbl[i], 1'b0);
      wait_idle(W + 10);
      step(1);
    end

    for (int i = 0; i < 16; i++) begin
      v = model(1'($urandom_range(1)), $urandom,
                (i == 7) ? W'(0) : W'($urandom >> $urandom_range(31)));
      start_op(v, 1'b0);
      wait_idle(W + 10);
      step(1);
    end

    // abort ten cycles into an op: no done, outputs unchanged
    start_op(model(1'b0, 32'd1000, 32'd3), 1'b0);
    step(9);
    ifc.abort = 1'b1;
    step(1);
    ifc.abort = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", W'(ifc.busy), '0);
    step(W + 4);
    chk("abort_keep_q", ifc.quotient, last_q);
    chk("abort_keep_r", ifc.remainder, last_r);

    // op together with abort is dropped
    ifc.abort = 1'b1; ifc.op_divu = 1'b1;
    ifc.dividend = 32'd77; ifc.divisor = 32'd5;
    step(1);
    ifc.abort = 1'b0; ifc.op_divu = 1'b0;
    @(negedge clk);
    chk("abort_op_busy", W'(ifc.busy), '0);
    step(W + 4);
    chk("abort_op_idle", W'(ifc.busy), '0);
    chk("abort_op_keep_q", ifc.quotient, last_q);

    // restart mid-RUN: only the second op completes
    start_op(model(1'b0, 32'd500, 32'd7), 1'b0);
    step(4);
    start_op('{1'b0, 32'd999, 32'd10, 32'd99, 32'd9, 1'b0}, 1'b1);
    wait_idle(W + 10);
    step(W);

    // op issued in the done cycle
    start_op('{1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0}, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (ifc.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      fail("done_cycle_wait");
      sb.delete();
    end
    start_op('{1'b1, -32'd100, 32'd7, -32'd14, -32'd2, 1'b0}, 1'b0);
    wait_idle(W + 10);
    step(1);

    // reset mid-RUN clears outputs on that edge
    start_op(model(1'b0, 32'd12345, 32'd11), 1'b0);
    step(5);
    rst = 1'b1;
    step(1);
    @(negedge clk);
    chk("rst_mid_q", ifc.quotient, '0);
    chk("rst_mid_r", ifc.remainder, '0);
    chk("rst_mid_flags", W'({ifc.busy, ifc.done, ifc.div_zero}), '0);
    rst = 1'b0;
    sb.delete();
    last_q = '0;
    last_r = '0;
    step(W + 4);
    chk("rst_mid_no_done", W'(ifc.busy), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
